// File: rtl/muldiv_unit.sv
// Iterative integer multiply/divide unit: single-cycle registered product,
// restoring radix-2 divide, fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [XLEN-1:0]   quo, rem, dvsr;
  logic [XLEN-1:0]   result_q;
  logic [2*XLEN-1:0] prod;
  logic [CW-1:0]     cnt;

  // Fast-path decision on the raw request inputs
  logic in_special;
  assign in_special = op[2] && ((b == '0) || (!op[0] && (a == MOST_NEG) && (b == '1)));

  logic q_div_zero, q_ovf;
  assign q_div_zero = (b_q == '0);
  assign q_ovf      = !op_q[0] && (a_q == MOST_NEG) && (b_q == '1);

  // Sign-extend to 2*XLEN so the low half of one unsigned product covers all variants
  logic              a_sx, b_sx;
  logic [2*XLEN-1:0] a_w, b_w, prod_full;
  assign a_sx      = (op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10);
  assign b_sx      = (op_q[1:0] == 2'b01);
  assign a_w       = {{XLEN{a_sx & a_q[XLEN-1]}}, a_q};
  assign b_w       = {{XLEN{b_sx & b_q[XLEN-1]}}, b_q};
  assign prod_full = a_w * b_w;

  logic            div_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [XLEN:0]   shifted, diff;
  assign div_signed = !op_q[0];
  assign a_neg      = div_signed & a_q[XLEN-1];
  assign b_neg      = div_signed & b_q[XLEN-1];
  assign a_mag      = a_neg ? -a_q : a_q;
  assign b_mag      = b_neg ? -b_q : b_q;
  assign shifted    = {rem, quo[XLEN-1]};
  assign diff       = shifted - {1'b0, dvsr};
  assign q_fix      = (a_neg ^ b_neg) ? -quo : quo;
  assign r_fix      = a_neg ? -rem : rem;

  logic [XLEN-1:0] done_result;
  always_comb begin
    done_result = '0;
    if (!op_q[2])
      done_result = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (q_div_zero)
      done_result = op_q[1] ? a_q : '1;
    else if (q_ovf)
      done_result = op_q[1] ? '0 : a_q;
    else
      done_result = op_q[1] ? r_fix : q_fix;
  end

  assign busy   = (state != IDLE);
  // Valid and the new result are presented combinationally in DONE so a late flush can still cancel them
  assign valid  = (state == DONE) && !flush;
  assign result = valid ? done_result : result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      prod     <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            cnt   <= '0;
            state <= (!op[2] || in_special) ? MUL : DIV;
          end
        end
        MUL: begin
          prod  <= prod_full;
          state <= DONE;
        end
        DIV: begin
          if (cnt == '0) begin
            quo  <= a_mag;
            rem  <= '0;
            dvsr <= b_mag;
          end else if (!diff[XLEN]) begin
            rem <= diff[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= shifted[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN)) state <= DONE;
        end
        DONE: begin
          result_q <= done_result;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected result/cycle,
// a negedge monitor pops and compares on every valid pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, valid;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          errors = 0;
  logic [31:0] last_result = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_valid: got result 0x%08h expected no valid (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("valid_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the unit idle; start is sampled at the next edge (cycle N).
  task automatic do_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] expv, input int lat, input int flush_off);
    int n;
    int stray;
    stray = (lat > 5) ? 5 : 1;
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    n     = cyc;
    if (flush_off == 0) sb.push_back('{res: expv, at: n + lat});
    for (int k = 1; k <= lat + 2; k++) begin
      step();
      start = (k == stray);
      flush = (k == flush_off);
      if (k == 1) begin
        a  = $urandom;
        b  = $urandom;
        op = 3'($urandom_range(0, 7));
      end
      if (flush_off == 0) begin
        if (k == lat) check("busy_in_done", {31'b0, busy}, 32'd1);
        if (k == lat + 1) begin
          check("busy_after_done", {31'b0, busy}, 32'd0);
          last_result = expv;
          break;
        end
      end else if (k == flush_off + 1) begin
        check("busy_after_flush", {31'b0, busy}, 32'd0);
        check("result_after_flush", result, last_result);
        break;
      end
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    #12;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_result", result, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Multiply family
    do_op(3'b001, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF, 2, 0);
    do_op(3'b011, 32'hFFFFFFFF, 32'd7,        32'h00000006, 2, 0);
    do_op(3'b000, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFF9, 2, 0);
    do_op(3'b010, 32'd2,        32'hFFFFFFFF, 32'h00000001, 2, 0);
    do_op(3'b001, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFF, 2, 0);
    do_op(3'b000, 32'h12345678, 32'h10,       32'h23456780, 2, 0);

    // Iterative divide
    do_op(3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 34, 0);
    do_op(3'b110, 32'd20,       32'hFFFFFFFD, 32'h00000002, 34, 0);
    do_op(3'b101, 32'd100,      32'd7,        32'h0000000E, 34, 0);
    do_op(3'b111, 32'd100,      32'd7,        32'h00000002, 34, 0);
    do_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0);
    do_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0);
    do_op(3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34, 0);

    // Divide by zero and signed overflow fast paths
    do_op(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2, 0);
    do_op(3'b111, 32'd5,        32'd0,        32'h00000005, 2, 0);
    do_op(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2, 0);
    do_op(3'b110, 32'h80000000, 32'd0,        32'h80000000, 2, 0);
    do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 0);
    do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2, 0);

    // Flush mid-divide with a stray start at N+5, then an immediate new request
    do_op(3'b101, 32'd1000,     32'd3,        32'h0, 34, 10);
    do_op(3'b101, 32'd1000,     32'd3,        32'h0000014D, 34, 0);
    // Flush landing in DONE
    do_op(3'b000, 32'd3,        32'd4,        32'h0, 2, 2);
    do_op(3'b000, 32'd3,        32'd4,        32'h0000000C, 2, 0);

    // Flush and start together while idle
    start = 1'b1;
    flush = 1'b1;
    op    = 3'b000;
    a     = 32'd9;
    b     = 32'd9;
    step();
    start = 1'b0;
    flush = 1'b0;
    check("flush_beats_start", {31'b0, busy}, 32'd0);

    // Reset in the middle of a divide
    start = 1'b1;
    op    = 3'b101;
    a     = 32'd77;
    b     = 32'd5;
    n     = cyc;
    for (int k = 1; k <= 20; k++) begin
      step();
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_valid", {31'b0, valid}, 32'd0);
    check("midreset_result", result, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    last_result = '0;
    for (int k = 0; k < 40; k++) step();
    check("post_reset_idle", {31'b0, busy}, 32'd0);

    // First edge after reset release must accept a request
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    do_op(3'b111, 32'd50,       32'd8,        32'h00000002, 34, 0);

    for (int k = 0; k < 5; k++) step();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width (supported values: 32 and 64).
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port start, input, 1: request to begin an operation; accepted only when busy=0.
REQ-005 Port op, input, 3: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port a, input, XLEN: operand 1 (dividend / multiplicand).
REQ-007 Port b, input, XLEN: operand 2 (divisor / multiplier).
REQ-008 Port flush, input, 1: abort any in-flight operation.
REQ-009 Port busy, output, 1: operation in flight; the block ignores start while busy=1.
REQ-010 Port valid, output, 1: one-cycle pulse marking result as new.
REQ-011 Port result, output, XLEN: operation result; holds its value until the next valid pulse.

Function
REQ-012 The FSM SHALL have states IDLE, MUL, DIV, DONE; busy SHALL be 1 in MUL, DIV and DONE.
REQ-013 The block SHALL accept a request when start=1 and state=IDLE (cycle N), latching op, a and b; later changes on the inputs SHALL NOT affect the operation.
REQ-014 For op[2]=0 the FSM SHALL go IDLE->MUL->DONE; the full 2*XLEN product SHALL be registered in MUL, and valid SHALL be 1 in cycle N+2.
REQ-015 Product selection SHALL be: MUL = low XLEN bits; MULH = high bits of signed*signed; MULHSU = high bits of signed a * unsigned b; MULHU = high bits of unsigned*unsigned.
REQ-016 For op[2]=1 with b!=0 and no overflow, the FSM SHALL go IDLE->DIV->DONE.
REQ-017 The divide SHALL be a restoring radix-2 divide on magnitudes, one quotient bit per cycle, with exactly XLEN iterations; valid SHALL be 1 in cycle N+XLEN+2.
REQ-018 Signed divide: the quotient SHALL be negated when the operand signs differ; the remainder SHALL take the sign of the dividend (rounding toward zero).
REQ-019 Divide by zero (b=0) SHALL take the fast path IDLE->MUL->DONE, with valid at N+2.
REQ-020 Divide by zero results: DIV/DIVU SHALL return all ones; REM/REMU SHALL return a.
REQ-021 Signed overflow (DIV/REM, a = most-negative value, b = all ones) SHALL take the fast path, with valid at N+2.
REQ-022 Signed overflow results: DIV SHALL return a; REM SHALL return 0.
REQ-023 In DONE, result SHALL update, valid SHALL pulse for one cycle, and the FSM SHALL return to IDLE; busy SHALL be 0 in cycle N+3 (multiply/fast path) or N+XLEN+3 (divide).
REQ-024 A start pulse that arrives while busy=1 SHALL be dropped and SHALL NOT be queued.
REQ-025 A flush in any non-IDLE state SHALL force IDLE on the next edge: no valid pulse, result unchanged, busy=0 on the following cycle.
REQ-026 When flush and start are asserted in the same cycle, flush SHALL win and the start SHALL be dropped.
REQ-027 A flush while in DONE SHALL suppress that cycle's valid pulse and SHALL leave result unchanged.

Reset
REQ-028 While rst_n=0, the block SHALL immediately set state=IDLE, busy=0, valid=0, result=0, and clear the internal operand, counter and remainder registers.
REQ-029 Reset asserted mid-operation SHALL discard that operation; no valid SHALL be produced after rst_n is released.
REQ-030 The first start SHALL be accepted on the first rising edge at which rst_n=1.

Verification (XLEN=32)
REQ-031 a=0xFFFFFFFF, b=7: MULH -> 0xFFFFFFFF and MULHU -> 0x00000006 at N+2; MUL -> 0xFFFFFFF9.
REQ-032 a=20, b=0xFFFFFFFD (-3): DIV -> 0xFFFFFFFA at N+34; REM -> 0x00000002 at N+34.
REQ-033 a=5, b=0: DIVU -> 0xFFFFFFFF and REMU -> 0x00000005, both at N+2.
REQ-034 a=0x80000000, b=0xFFFFFFFF: DIV -> 0x80000000 and REM -> 0x00000000, both at N+2.
REQ-035 DIVU started at N, extra start at N+5, flush at N+10: no valid pulse, busy=0 at N+11, result unchanged, and a new start at N+11 is accepted.
REQ-036 rst_n pulled low at N+20 during a divide: outputs are 0 immediately, and no valid pulse appears after rst_n is released.
